// File: rtl/sequenciador_controle.sv
// SAP-1 control sequencer: six-state one-hot ring (T1..T6) with opcode decode
// that drives every datapath load/enable strobe, single-step mode and sticky halt.
module sequenciador_controle #(
  parameter logic [3:0] OP_LDA = 4'b0000,
  parameter logic [3:0] OP_ADD = 4'b0001,
  parameter logic [3:0] OP_SUB = 4'b0010,
  parameter logic [3:0] OP_OUT = 4'b1110,
  parameter logic [3:0] OP_HLT = 4'b1111
) (
  input  logic       clk,
  input  logic       clr,
  input  logic [3:0] opcode,
  input  logic       auto,
  input  logic       step,
  output logic [5:0] t_state,
  output logic       pc_inc,
  output logic       pc_en,
  output logic       mar_load,
  output logic       ram_en,
  output logic       ir_load,
  output logic       ir_en,
  output logic       a_load,
  output logic       a_en,
  output logic       sub,
  output logic       alu_en,
  output logic       b_load,
  output logic       out_load,
  output logic       halt
);

  localparam logic [5:0] T1 = 6'b000001;

  logic [5:0] t_state_q, t_state_d;
  logic       halt_q, halt_d;
  logic       adv;
  logic       legal;

  // Strobes are gated by adv so each one lasts exactly one advancing cycle.
  assign adv   = ~halt_q & ~clr & (auto | step);
  assign legal = (t_state_q != 6'd0) && ((t_state_q & (t_state_q - 6'd1)) == 6'd0);

  always_ff @(posedge clk) begin
    if (clr) begin
      t_state_q <= T1;
      halt_q    <= 1'b0;
    end else begin
      t_state_q <= t_state_d;
      halt_q    <= halt_d;
    end
  end

  always_comb begin
    t_state_d = t_state_q;
    halt_d    = halt_q;
    if (!legal) begin
      t_state_d = T1;
    end else if (adv) begin
      // HLT freezes the ring in T4 instead of rotating.
      if (t_state_q[3] && opcode == OP_HLT) begin
        halt_d = 1'b1;
      end else begin
        t_state_d = {t_state_q[4:0], t_state_q[5]};
      end
    end
  end

  always_comb begin
    pc_inc   = 1'b0;
    pc_en    = 1'b0;
    mar_load = 1'b0;
    ram_en   = 1'b0;
    ir_load  = 1'b0;
    ir_en    = 1'b0;
    a_load   = 1'b0;
    a_en     = 1'b0;
    sub      = 1'b0;
    alu_en   = 1'b0;
    b_load   = 1'b0;
    out_load = 1'b0;
    if (adv && legal) begin
      if (t_state_q[0]) begin
        pc_en    = 1'b1;
        mar_load = 1'b1;
      end
      if (t_state_q[1]) begin
        pc_inc = 1'b1;
      end
      if (t_state_q[2]) begin
        ram_en  = 1'b1;
        ir_load = 1'b1;
      end
      if (t_state_q[3]) begin
        case (opcode)
          OP_LDA, OP_ADD, OP_SUB: begin
            ir_en    = 1'b1;
            mar_load = 1'b1;
          end
          OP_OUT: begin
            a_en     = 1'b1;
            out_load = 1'b1;
          end
          default: ;
        endcase
      end
      if (t_state_q[4]) begin
        case (opcode)
          OP_LDA: begin
            ram_en = 1'b1;
            a_load = 1'b1;
          end
          OP_ADD, OP_SUB: begin
            ram_en = 1'b1;
            b_load = 1'b1;
          end
          default: ;
        endcase
      end
      if (t_state_q[5]) begin
        case (opcode)
          OP_ADD: begin
            alu_en = 1'b1;
            a_load = 1'b1;
          end
          OP_SUB: begin
            alu_en = 1'b1;
            a_load = 1'b1;
            sub    = 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  assign t_state = t_state_q;
  assign halt    = halt_q;

endmodule

// File: doc/sequenciador_controle.md
Name: sequenciador_controle

Overview:
- Control sequencer for the SAP-1 datapath.
- Runs a six-state one-hot ring counter (T1..T6) and decodes the 4-bit opcode from the instruction register.
- Drives every load/enable strobe of PC, MAR, RAM, IR, accumulator A, register B, the adder/subtractor (sub, alu_en) and the output register.
- Supports free-run and single-step modes, plus a sticky halt.

Parameters:
OP_LDA, 4'b0000, opcode of LDA
OP_ADD, 4'b0001, opcode of ADD
OP_SUB, 4'b0010, opcode of SUB
OP_OUT, 4'b1110, opcode of OUT
OP_HLT, 4'b1111, opcode of HLT

Ports:
clk  in  1  system clock, all state updates on rising edge
clr  in  1  reset, synchronous, active-high
opcode  in  4  IR[7:4], valid from T4 onward
auto  in  1  1 = free run; 0 = single-step
step  in  1  one-cycle advance pulse, used only when auto=0
t_state  out  6  one-hot ring state, bit0=T1 .. bit5=T6
pc_inc  out  1  Cp: PC increment
pc_en  out  1  Ep: PC drives bus
mar_load  out  1  Lm: MAR loads bus
ram_en  out  1  CE: RAM drives bus
ir_load  out  1  Li: IR loads bus
ir_en  out  1  Ei: IR operand field drives bus
a_load  out  1  La: accumulator loads bus
a_en  out  1  Ea: accumulator drives bus
sub  out  1  Su: adder/subtractor in subtract mode
alu_en  out  1  Eu: adder/subtractor drives bus
b_load  out  1  Lb: B register loads bus
out_load  out  1  Lo: output register loads bus
halt  out  1  registered; 1 once HLT executed

Behaviour:
- Reset (clr=1 at edge): t_state <= 6'b000001, halt <= 0. While clr=1, all strobe outputs are forced to 0 combinationally. clr overrides step, auto and halt in every state, including mid-instruction.
- Advance qualifier: adv = ~halt & ~clr & (auto | step).
- On an edge with adv=1, t_state rotates T1->T2->...->T6->T1. With adv=0, t_state holds.
- Strobes are combinational: decode(t_state, opcode) AND adv. In step mode each strobe is therefore active for exactly the one cycle the state advances, so there are no repeated loads or increments.
- Fetch, opcode-independent:
  - T1: pc_en, mar_load
  - T2: pc_inc
  - T3: ram_en, ir_load
- Execute:
  - LDA: T4 ir_en, mar_load | T5 ram_en, a_load | T6 none
  - ADD: T4 ir_en, mar_load | T5 ram_en, b_load | T6 alu_en, a_load
  - SUB: as ADD, plus sub=1 in T6 only (sub=0 in all other cycles)
  - OUT: T4 a_en, out_load | T5, T6 none
  - HLT: T4 no strobes; on that edge, if adv=1, halt <= 1 and t_state holds T4.
  - Any other opcode: NOP, T4..T6 no strobes.
- Halted: t_state frozen, all strobes 0, step/auto ignored. Only clr exits halt.
- Invariants:
  - At most one bus driver (pc_en, ram_en, ir_en, a_en, alu_en) is high in any cycle.
  - At most one of a_load/b_load is high in any cycle.
  - Instruction latency is a fixed 6 advancing cycles, independent of opcode.
- Illegal t_state (not one-hot, e.g. after an upset) recovers to 6'b000001 on the next edge; strobes are 0 while illegal.
- Mode switching: a change of auto takes effect in the same cycle. A step pulse while auto=1 has no extra effect.

Test Plan:
- Reset/fetch: clr=1 for 2 cycles, then auto=1, opcode=0000 -> after release t_state=000001 with pc_en=mar_load=1; next cycle pc_inc=1; next cycle ram_en=ir_load=1; all strobes 0 during clr.
- LDA/ADD/SUB program: opcodes 0000, 0001, 0010 in sequence, free run -> each instruction takes 6 cycles. ADD T6 gives alu_en=a_load=1, sub=0. SUB T6 gives alu_en=a_load=sub=1. Bus-driver one-hot assertion holds every cycle.
- OUT then HLT: opcode 1110 -> T4 a_en=out_load=1. Next instruction opcode 1111 -> halt=1 after T4 edge, t_state stays 001000 for 20 further cycles with all strobes 0. Then clr=1 -> t_state=000001, halt=0.
- Single-step: auto=0, step pulses every 5th cycle -> t_state advances once per pulse. pc_inc is high for exactly 1 cycle per instruction (total 3 over 3 instructions); strobes are 0 in non-step cycles.
- Reset mid-instruction: assert clr during ADD T5 -> b_load drops to 0 in that cycle; the next edge gives t_state=000001 and fetch restarts.
- Undefined opcode 0111 -> T4..T6 all strobes 0, returns to T1 after 6 cycles; halt stays 0.
